// File: rtl/pwm_timebase_controller.sv
// Shared PWM timebase: prescaled free-running counter with a double-buffered period,
// start / graceful stop / abort sequencing and a sticky period-wrap interrupt.
module pwm_timebase_controller #(
   parameter int WIDTH    = 16,
   parameter int PS_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [WIDTH-1:0]    cfg_top,
   input  logic [PS_WIDTH-1:0] cfg_prescale,
   input  logic                cfg_write,
   input  logic                start,
   input  logic                stop,
   input  logic                abort,
   input  logic                irq_enable,
   input  logic                irq_clear,
   output logic [WIDTH-1:0]    counter_value,
   output logic                channel_enable,
   output logic                period_start,
   output logic                running,
   output logic                irq
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t              state_r;
   logic [WIDTH-1:0]    counter_r;
   logic [PS_WIDTH-1:0] ps_cnt_r;
   logic [WIDTH-1:0]    shadow_top_r;
   logic [PS_WIDTH-1:0] shadow_ps_r;
   logic [WIDTH-1:0]    act_top_r;
   logic [PS_WIDTH-1:0] act_ps_r;
   logic                period_start_r;
   logic                running_r;
   logic                irq_r;

   logic tick_s;
   logic wrap_s;

   // Tick and wrap qualifiers; abort suppresses a coincident wrap so it neither reloads nor raises irq.
   always_comb begin
      tick_s = 1'b0;
      wrap_s = 1'b0;
      if (state_r != ST_IDLE) begin
         tick_s = (ps_cnt_r == act_ps_r);
         wrap_s = tick_s && (counter_r == act_top_r) && !abort;
      end else begin
         tick_s = 1'b0;
         wrap_s = 1'b0;
      end
   end

   // Shadow configuration registers, writable in any state.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_top_r <= {WIDTH{1'b0}};
         shadow_ps_r  <= {PS_WIDTH{1'b0}};
      end else if (cfg_write) begin
         shadow_top_r <= cfg_top;
         shadow_ps_r  <= cfg_prescale;
      end
   end

   // Sequencer FSM with counter, prescaler, active registers and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= ST_IDLE;
         counter_r      <= {WIDTH{1'b0}};
         ps_cnt_r       <= {PS_WIDTH{1'b0}};
         act_top_r      <= {WIDTH{1'b0}};
         act_ps_r       <= {PS_WIDTH{1'b0}};
         period_start_r <= 1'b0;
         running_r      <= 1'b0;
      end else if (abort) begin
         state_r        <= ST_IDLE;
         counter_r      <= {WIDTH{1'b0}};
         ps_cnt_r       <= {PS_WIDTH{1'b0}};
         period_start_r <= 1'b0;
         running_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               counter_r <= {WIDTH{1'b0}};
               ps_cnt_r  <= {PS_WIDTH{1'b0}};
               if (start) begin
                  state_r        <= ST_RUN;
                  act_top_r      <= shadow_top_r;
                  act_ps_r       <= shadow_ps_r;
                  period_start_r <= 1'b1;
                  running_r      <= 1'b1;
               end else begin
                  period_start_r <= 1'b0;
                  running_r      <= 1'b0;
               end
            end
            ST_RUN, ST_DRAIN: begin
               if (tick_s) begin
                  ps_cnt_r <= {PS_WIDTH{1'b0}};
                  if (wrap_s) begin
                     counter_r <= {WIDTH{1'b0}};
                     act_top_r <= shadow_top_r;
                     act_ps_r  <= shadow_ps_r;
                  end else begin
                     counter_r <= counter_r + {{(WIDTH-1){1'b0}}, 1'b1};
                  end
               end else begin
                  ps_cnt_r <= ps_cnt_r + {{(PS_WIDTH-1){1'b0}}, 1'b1};
               end

               // A drain cancelled by start keeps counting as a normal run, even on a wrap cycle.
               if (state_r == ST_RUN) begin
                  state_r        <= stop ? ST_DRAIN : ST_RUN;
                  period_start_r <= wrap_s;
                  running_r      <= 1'b1;
               end else if (start && !stop) begin
                  state_r        <= ST_RUN;
                  period_start_r <= wrap_s;
                  running_r      <= 1'b1;
               end else if (wrap_s) begin
                  state_r        <= ST_IDLE;
                  period_start_r <= 1'b0;
                  running_r      <= 1'b0;
               end else begin
                  state_r        <= ST_DRAIN;
                  period_start_r <= 1'b0;
                  running_r      <= 1'b1;
               end
            end
            default: begin
               state_r        <= ST_IDLE;
               counter_r      <= {WIDTH{1'b0}};
               ps_cnt_r       <= {PS_WIDTH{1'b0}};
               period_start_r <= 1'b0;
               running_r      <= 1'b0;
            end
         endcase
      end
   end

   // Sticky wrap interrupt; a set wins over a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_r <= 1'b0;
      end else if (wrap_s && irq_enable) begin
         irq_r <= 1'b1;
      end else if (irq_clear) begin
         irq_r <= 1'b0;
      end
   end

   assign counter_value  = counter_r;
   assign channel_enable = running_r;
   assign running        = running_r;
   assign period_start   = period_start_r;
   assign irq            = irq_r;

endmodule

// File: tb/tb_pwm_timebase_controller.sv
// Directed bench for pwm_timebase_controller with hand-computed expected values.
module tb_pwm_timebase_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cfg_top = 16'd0;
   logic [7:0]  cfg_prescale = 8'd0;
   logic        cfg_write = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        abort = 1'b0;
   logic        irq_enable = 1'b0;
   logic        irq_clear = 1'b0;
   logic [15:0] counter_value;
   logic        channel_enable;
   logic        period_start;
   logic        running;
   logic        irq;

   int total = 0;
   int bad = 0;

   pwm_timebase_controller #(.WIDTH(16), .PS_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .cfg_top(cfg_top), .cfg_prescale(cfg_prescale),
      .cfg_write(cfg_write), .start(start), .stop(stop), .abort(abort),
      .irq_enable(irq_enable), .irq_clear(irq_clear), .counter_value(counter_value),
      .channel_enable(channel_enable), .period_start(period_start), .running(running),
      .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic write_cfg(input logic [15:0] top, input logic [7:0] ps);
      cfg_top = top;
      cfg_prescale = ps;
      cfg_write = 1'b1;
      cyc();
      cfg_write = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic do_abort();
      abort = 1'b1;
      cyc();
      abort = 1'b0;
   endtask

   initial begin
      cyc();
      cyc();
      rst = 1'b0;
      chk("rst_counter", counter_value, 0);
      chk("rst_enable", channel_enable, 0);
      chk("rst_pstart", period_start, 0);
      chk("rst_running", running, 0);
      chk("rst_irq", irq, 0);

      // 1: top=3, prescale=0
      write_cfg(16'd3, 8'd0);
      irq_enable = 1'b1;
      do_start();
      chk("t1_cnt0", counter_value, 0);
      chk("t1_ps0", period_start, 1);
      chk("t1_en0", channel_enable, 1);
      chk("t1_irq0", irq, 0);
      for (int k = 1; k <= 8; k++) begin
         cyc();
         chk("t1_cnt", counter_value, k % 4);
         chk("t1_pstart", period_start, (k % 4 == 0) ? 1 : 0);
         chk("t1_irq", irq, (k >= 4) ? 1 : 0);
      end
      do_abort();
      chk("t1_abort_run", running, 0);
      chk("t1_irq_kept", irq, 1);
      irq_clear = 1'b1;
      cyc();
      irq_clear = 1'b0;
      chk("t1_irq_clr", irq, 0);
      irq_enable = 1'b0;

      // 2: top=2, prescale=2, rewrite top=5 mid-period
      write_cfg(16'd2, 8'd2);
      do_start();
      chk("t2_cnt0", counter_value, 0);
      for (int n = 1; n <= 27; n++) begin
         cyc();
         chk("t2_cnt", counter_value, (n < 9) ? n / 3 : ((n < 27) ? (n - 9) / 3 : 0));
         chk("t2_pstart", period_start, (n == 9 || n == 27) ? 1 : 0);
         if (n == 4) begin
            cfg_top = 16'd5;
            cfg_write = 1'b1;
         end else begin
            cfg_write = 1'b0;
         end
      end
      do_abort();

      // 3: graceful stop at counter=1, top=4
      write_cfg(16'd4, 8'd0);
      do_start();
      for (int n = 1; n <= 6; n++) begin
         cyc();
         chk("t3_cnt", counter_value, (n <= 4) ? n : 0);
         chk("t3_run", running, (n <= 4) ? 1 : 0);
         chk("t3_en", channel_enable, (n <= 4) ? 1 : 0);
         chk("t3_pstart", period_start, 0);
         stop = (n == 1) ? 1'b1 : 1'b0;
      end

      // 4: stop then start in drain, then abort at counter=3
      do_start();
      for (int n = 1; n <= 10; n++) begin
         cyc();
         chk("t4_cnt", counter_value, (n <= 4) ? n : ((n <= 8) ? n - 5 : 0));
         chk("t4_run", running, (n <= 8) ? 1 : 0);
         chk("t4_pstart", period_start, (n == 5) ? 1 : 0);
         stop  = (n == 1) ? 1'b1 : 1'b0;
         start = (n == 2) ? 1'b1 : 1'b0;
         abort = (n == 8) ? 1'b1 : 1'b0;
      end

      // 5: top=0 prescale=0, irq_clear coincident with wrap
      write_cfg(16'd0, 8'd0);
      irq_enable = 1'b1;
      do_start();
      chk("t5_ps0", period_start, 1);
      chk("t5_irq0", irq, 0);
      cyc();
      chk("t5_ps1", period_start, 1);
      chk("t5_irq1", irq, 1);
      irq_clear = 1'b1;
      cyc();
      irq_clear = 1'b0;
      chk("t5_irq_setwins", irq, 1);
      for (int n = 0; n < 3; n++) begin
         cyc();
         chk("t5_pstart", period_start, 1);
         chk("t5_cnt", counter_value, 0);
      end

      // 6: reset in RUN with irq=1 and a pending shadow top=7
      write_cfg(16'd7, 8'd0);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("t6_cnt", counter_value, 0);
      chk("t6_en", channel_enable, 0);
      chk("t6_run", running, 0);
      chk("t6_pstart", period_start, 0);
      chk("t6_irq", irq, 0);
      irq_enable = 1'b0;
      do_start();
      chk("t6_start_ps", period_start, 1);
      cyc();
      chk("t6_top0_cnt", counter_value, 0);
      chk("t6_top0_ps", period_start, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
